// File: rtl/attack_inverse_search_if.sv
// Request/result bundle for attack_inverse_search: start/level in, busy/valid/addr out.
interface attack_inverse_search_if;
  logic        start;
  logic [12:0] level;
  logic        busy;
  logic        valid;
  logic [21:0] addr;

  modport master (output start, output level, input busy, input valid, input addr);
  modport slave  (input start, input level, output busy, output valid, output addr);
endinterface

// File: rtl/attack_inverse_search.sv
// Inverse attack-curve lookup: binary search over the AttackTable curve, then restoring division
// for the fractional part. Macro VM2413_ATTACK_INV_ROUND_EN selects a rounded 9-step quotient.
package vm2413_pkg;
  localparam logic [6:0] AR_ADJUST [128] = '{
    7'd0,   7'd0,   7'd0,   7'd0,   7'd0,   7'd1,   7'd1,   7'd1,
    7'd1,   7'd1,   7'd2,   7'd2,   7'd2,   7'd2,   7'd3,   7'd3,
    7'd3,   7'd3,   7'd4,   7'd4,   7'd4,   7'd4,   7'd4,   7'd5,
    7'd5,   7'd5,   7'd6,   7'd6,   7'd6,   7'd7,   7'd7,   7'd7,
    7'd8,   7'd8,   7'd8,   7'd9,   7'd9,   7'd9,   7'd10,  7'd10,
    7'd10,  7'd11,  7'd11,  7'd11,  7'd12,  7'd12,  7'd13,  7'd13,
    7'd14,  7'd14,  7'd14,  7'd15,  7'd15,  7'd16,  7'd16,  7'd17,
    7'd17,  7'd18,  7'd18,  7'd19,  7'd19,  7'd20,  7'd20,  7'd21,
    7'd21,  7'd22,  7'd22,  7'd23,  7'd24,  7'd24,  7'd25,  7'd26,
    7'd26,  7'd27,  7'd28,  7'd28,  7'd29,  7'd30,  7'd31,  7'd31,
    7'd32,  7'd33,  7'd34,  7'd35,  7'd36,  7'd36,  7'd37,  7'd38,
    7'd39,  7'd40,  7'd41,  7'd42,  7'd43,  7'd44,  7'd45,  7'd47,
    7'd48,  7'd49,  7'd50,  7'd52,  7'd53,  7'd54,  7'd56,  7'd57,
    7'd59,  7'd60,  7'd62,  7'd64,  7'd66,  7'd67,  7'd69,  7'd71,
    7'd73,  7'd75,  7'd78,  7'd80,  7'd82,  7'd85,  7'd88,  7'd90,
    7'd93,  7'd96,  7'd100, 7'd103, 7'd107, 7'd111, 7'd117, 7'd127
  };
endpackage

module attack_inverse_search
  import vm2413_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    clkena,
  attack_inverse_search_if.slave  bus
);

`ifdef VM2413_ATTACK_INV_ROUND_EN
  localparam int         QW       = 9;
  localparam logic [3:0] DIV_LAST = 4'd8;
`else
  localparam int         QW       = 8;
  localparam logic [3:0] DIV_LAST = 4'd7;
`endif

  typedef enum logic [2:0] {S_IDLE, S_SEARCH, S_PREP, S_DIV, S_DONE} state_e;

  state_e          state_q, state_d;
  logic [12:0]     level_q, level_d;
  logic [6:0]      idx_q, idx_d;
  logic [2:0]      bit_q, bit_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [13:0]     rem_q, rem_d;
  logic [13:0]     den_q, den_d;
  logic [QW-1:0]   quo_q, quo_d;
  logic [21:0]     addr_q, addr_d;
  logic            valid_q, valid_d;
  logic            busy_q, busy_d;

  logic [6:0]      cand_s;
  logic [14:0]     shifted_s;
  logic [7:0]      q_fin_s;
`ifdef VM2413_ATTACK_INV_ROUND_EN
  logic [9:0]      q_inc_s;
`endif

  // Next-state and datapath for the search / divide sequencer
  always_comb begin
    state_d   = state_q;
    level_d   = level_q;
    idx_d     = idx_q;
    bit_d     = bit_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    den_d     = den_q;
    quo_d     = quo_q;
    addr_d    = addr_q;
    valid_d   = 1'b0;
    busy_d    = busy_q;
    cand_s    = idx_q | (7'd1 << bit_q);
    shifted_s = {rem_q, 1'b0};
`ifdef VM2413_ATTACK_INV_ROUND_EN
    q_inc_s   = {1'b0, quo_q} + 10'd1;
    q_fin_s   = q_inc_s[9] ? 8'hFF : q_inc_s[8:1];
`else
    q_fin_s   = quo_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          level_d = bus.level;
          idx_d   = 7'd0;
          bit_d   = 3'd6;
          quo_d   = '0;
          busy_d  = 1'b1;
          // Top segment has no successor entry to interpolate against
          if (bus.level >= 13'd8128) begin
            idx_d   = 7'h7F;
            state_d = S_DONE;
          end else begin
            state_d = S_SEARCH;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SEARCH: begin
        if ((cand_s <= 7'd126) && ({AR_ADJUST[cand_s], 6'b0} <= level_q)) begin
          idx_d = cand_s;
        end else begin
          idx_d = idx_q;
        end
        if (bit_q == 3'd0) begin
          state_d = S_PREP;
        end else begin
          bit_d = bit_q - 3'd1;
        end
      end
      S_PREP: begin
        rem_d   = {1'b0, level_q - {AR_ADJUST[idx_q], 6'b0}};
        den_d   = {1'b0, AR_ADJUST[idx_q + 7'd1] - AR_ADJUST[idx_q], 6'b0};
        cnt_d   = 4'd0;
        state_d = S_DIV;
      end
      S_DIV: begin
        // Difference is below den, so the low 14 bits carry the exact remainder
        if (shifted_s >= {1'b0, den_q}) begin
          rem_d = shifted_s[13:0] - den_q;
          quo_d = {quo_q[QW-2:0], 1'b1};
        end else begin
          rem_d = shifted_s[13:0];
          quo_d = {quo_q[QW-2:0], 1'b0};
        end
        if (cnt_q == DIV_LAST) begin
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_DONE: begin
        addr_d  = {idx_q, q_fin_s, 7'b0};
        valid_d = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State register, advanced only on enabled edges
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      level_q <= 13'd0;
      idx_q   <= 7'd0;
      bit_q   <= 3'd0;
      cnt_q   <= 4'd0;
      rem_q   <= 14'd0;
      den_q   <= 14'd0;
      quo_q   <= '0;
      addr_q  <= 22'd0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else if (clkena) begin
      state_q <= state_d;
      level_q <= level_d;
      idx_q   <= idx_d;
      bit_q   <= bit_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      den_q   <= den_d;
      quo_q   <= quo_d;
      addr_q  <= addr_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.busy  = busy_q;
  assign bus.valid = valid_q;
  assign bus.addr  = addr_q;

endmodule
